// File: rtl/bmem_arbiter_pkg.sv
// Shared types and line geometry for the banked-memory arbiter.
package bmem_arbiter_pkg;

   localparam int unsigned BEAT_W   = 64;
   localparam int unsigned BEATS    = 4;
   localparam int unsigned LINE_W   = BEAT_W * BEATS;
   localparam int unsigned OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_BURST,
      DONE
   } state_t;

endpackage

// File: rtl/bmem_rr_arb.sv
// Two-client round-robin grant. prio_d set means the D-cache wins a tie.
module bmem_rr_arb
   import bmem_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic req_i,
   input  logic req_d,
   input  logic accept,
   output logic grant_d
);

   logic prio_d;

   // Lone requester always wins; on a tie the prioritised client wins.
   always_comb begin
      grant_d = 1'b0;
      if (req_d && req_i) begin
         grant_d = prio_d;
      end else if (req_d) begin
         grant_d = 1'b1;
      end
   end

   // Pass priority to whichever client was not just granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prio_d <= 1'b1;
      end else if (accept) begin
         prio_d <= !grant_d;
      end
   end

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates I-cache line reads and D-cache line reads/writebacks onto a
// single beat-wide banked-memory port, one transaction at a time.
module bmem_arbiter
   import bmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned BEAT_W = bmem_arbiter_pkg::BEAT_W,
   parameter int unsigned BEATS  = bmem_arbiter_pkg::BEATS
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic                      i_read,
   output logic [BEAT_W*BEATS-1:0]   i_rdata,
   output logic                      i_resp,
   input  logic [ADDR_W-1:0]         d_addr,
   input  logic                      d_read,
   input  logic                      d_write,
   input  logic [BEAT_W*BEATS-1:0]   d_wdata,
   output logic [BEAT_W*BEATS-1:0]   d_rdata,
   output logic                      d_resp,
   output logic [ADDR_W-1:0]         bmem_addr,
   output logic                      bmem_read,
   output logic                      bmem_write,
   output logic [BEAT_W-1:0]         bmem_wdata,
   input  logic                      bmem_ready,
   input  logic [ADDR_W-1:0]         bmem_raddr,
   input  logic [BEAT_W-1:0]         bmem_rdata,
   input  logic                      bmem_rvalid
);

   localparam int unsigned LINE  = BEAT_W * BEATS;
   localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BEATS - 1);
   localparam logic [ADDR_W-1:0] ALIGN = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

   state_t            state_q, state_d;
   logic              client_d_q;
   logic [ADDR_W-1:0] addr_q;
   logic [LINE-1:0]   wdata_q;
   logic [LINE-1:0]   line_q;
   logic [LINE-1:0]   line_nx;
   logic [CNT_W-1:0]  k_q;
   logic              req_d;
   logic              grant_d;
   logic              accept;
   logic              beat_hit;
   logic              last_beat;

   // A simultaneous read+write from the D-cache is handled as a write.
   assign req_d     = d_read | d_write;
   assign beat_hit  = (state_q == RD_WAIT) && bmem_rvalid && (bmem_raddr == addr_q);
   assign last_beat = (k_q == LAST);

   bmem_rr_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (i_read),
      .req_d   (req_d),
      .accept  (accept),
      .grant_d (grant_d)
   );

   // Merge the arriving beat into the partially assembled line.
   always_comb begin
      line_nx = line_q;
      line_nx[k_q*BEAT_W +: BEAT_W] = bmem_rdata;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and memory/response strobes.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
      i_resp     = 1'b0;
      d_resp     = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_read || req_d) begin
               accept  = 1'b1;
               state_d = (grant_d && d_write) ? WR_BURST : RD_REQ;
            end
         end
         RD_REQ: begin
            bmem_read = 1'b1;
            bmem_addr = addr_q;
            if (bmem_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (beat_hit && last_beat) state_d = DONE;
         end
         WR_BURST: begin
            bmem_write = 1'b1;
            bmem_addr  = addr_q;
            bmem_wdata = wdata_q[k_q*BEAT_W +: BEAT_W];
            if (bmem_ready && last_beat) state_d = DONE;
         end
         DONE: begin
            i_resp  = !client_d_q;
            d_resp  = client_d_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latch, beat counter, line assembly and per-client read lines.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         client_d_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         line_q     <= '0;
         k_q        <= '0;
         i_rdata    <= '0;
         d_rdata    <= '0;
      end else begin
         if (accept) begin
            client_d_q <= grant_d;
            addr_q     <= (grant_d ? d_addr : i_addr) & ALIGN;
            k_q        <= '0;
            if (grant_d) wdata_q <= d_wdata;
         end
         if (beat_hit) begin
            line_q <= line_nx;
            k_q    <= k_q + 1'b1;
            if (last_beat) begin
               if (client_d_q) d_rdata <= line_nx;
               else            i_rdata <= line_nx;
            end
         end
         if ((state_q == WR_BURST) && bmem_ready) begin
            k_q <= k_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bmem_arbiter.sv
// Scoreboard bench for bmem_arbiter: stimulus queues expected memory
// commands and client responses; a negedge monitor pops and compares.
module tb_bmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_addr;
   logic         i_read;
   logic [255:0] i_rdata;
   logic         i_resp;
   logic [31:0]  d_addr;
   logic         d_read;
   logic         d_write;
   logic [255:0] d_wdata;
   logic [255:0] d_rdata;
   logic         d_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      bit           is_d;
      bit           is_rd;
      logic [255:0] line;
   } resp_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [63:0] data;
   } cmd_t;

   resp_t exp_resp[$];
   cmd_t  exp_cmd[$];

   localparam logic [255:0] L1  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] LW  = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                                   64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
   localparam logic [255:0] L3A = {64'h0D03_0000_0000_0003, 64'h0D02_0000_0000_0002,
                                   64'h0D01_0000_0000_0001, 64'h0D00_0000_0000_0000};
   localparam logic [255:0] L3B = {64'h0103_0000_0000_0003, 64'h0102_0000_0000_0002,
                                   64'h0101_0000_0000_0001, 64'h0100_0000_0000_0000};
   localparam logic [255:0] L3C = {64'h1D03_1111_0000_0003, 64'h1D02_1111_0000_0002,
                                   64'h1D01_1111_0000_0001, 64'h1D00_1111_0000_0000};
   localparam logic [255:0] L3D = {64'h1103_2222_0000_0003, 64'h1102_2222_0000_0002,
                                   64'h1101_2222_0000_0001, 64'h1100_2222_0000_0000};
   localparam logic [255:0] L4  = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                                   64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
   localparam logic [255:0] LW2 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
                                   64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};
   localparam logic [255:0] L5A = {64'h5A5A_0000_0000_0004, 64'h5A5A_0000_0000_0003,
                                   64'h5A5A_0000_0000_0002, 64'h5A5A_0000_0000_0001};
   localparam logic [255:0] L5B = {64'h5B5B_0000_0000_0004, 64'h5B5B_0000_0000_0003,
                                   64'h5B5B_0000_0000_0002, 64'h5B5B_0000_0000_0001};

   bmem_arbiter #(
      .ADDR_W (32),
      .BEAT_W (64),
      .BEATS  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_addr      (i_addr),
      .i_read      (i_read),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_addr      (d_addr),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .bmem_addr   (bmem_addr),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_ready  (bmem_ready),
      .bmem_raddr  (bmem_raddr),
      .bmem_rdata  (bmem_rdata),
      .bmem_rvalid (bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: memory-side commands and client responses against the queues.
   always @(negedge clk) begin : monitor
      cmd_t  c;
      resp_t r;
      if (rst) begin
         if (bmem_read || bmem_write) begin
            chk("strobe_exclusive", bmem_read & bmem_write, 0);
            if (exp_cmd.size() == 0) begin
               chk("unexpected_cmd", {bmem_write, bmem_read}, 0);
            end else begin
               c = exp_cmd[0];
               chk("cmd_type", bmem_write, c.wr);
               chk("bmem_addr", bmem_addr, c.addr);
               if (c.wr) chk("bmem_wdata", bmem_wdata, c.data);
               if (bmem_ready) void'(exp_cmd.pop_front());
            end
         end
         if (i_resp || d_resp) begin
            chk("resp_exclusive", i_resp & d_resp, 0);
            if (exp_resp.size() == 0) begin
               chk("unexpected_resp", {d_resp, i_resp}, 0);
            end else begin
               r = exp_resp.pop_front();
               chk("resp_client", d_resp, r.is_d);
               if (r.is_rd) begin
                  if (r.is_d) chk("d_rdata", d_rdata, r.line);
                  else        chk("i_rdata", i_rdata, r.line);
               end
            end
         end
      end
   end

   task automatic expect_read(input bit is_d, input logic [31:0] a, input logic [255:0] line);
      exp_cmd.push_back('{wr: 1'b0, addr: a, data: 64'h0});
      exp_resp.push_back('{is_d: is_d, is_rd: 1'b1, line: line});
   endtask

   task automatic expect_write(input logic [31:0] a, input logic [255:0] line);
      for (int k = 0; k < 4; k++) begin
         exp_cmd.push_back('{wr: 1'b1, addr: a, data: line[k*64 +: 64]});
      end
      exp_resp.push_back('{is_d: 1'b1, is_rd: 1'b0, line: '0});
   endtask

   // Memory side of a read: hold off ready, then return nbeats beats.
   // Stray rvalid while the command is still pending must be ignored.
   task automatic serve_read(input logic [31:0] a, input int delay, input logic [255:0] line,
                             input bit foreign, input int nbeats, input bit is_d);
      int n = 0;
      while (!bmem_read && n < 50) begin
         tick();
         n++;
      end
      chk("rd_req_seen", bmem_read, 1);
      repeat (delay) begin
         bmem_rvalid = 1'b1;
         bmem_raddr  = a;
         bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
         tick();
      end
      bmem_rvalid = 1'b0;
      bmem_ready  = 1'b1;
      tick();
      bmem_ready  = 1'b0;
      for (int k = 0; k < nbeats; k++) begin
         if (foreign && k == 2) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_9000;
            bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            bmem_rvalid = 1'b0;
            tick();
         end
         bmem_rvalid = 1'b1;
         bmem_raddr  = a;
         bmem_rdata  = line[k*64 +: 64];
         tick();
      end
      bmem_rvalid = 1'b0;
      if (nbeats == 4) chk("resp_latency", is_d ? d_resp : i_resp, 1);
   endtask

   // Memory side of a write: ready follows pat[0..len-1], one bit per cycle.
   task automatic serve_write(input logic [7:0] pat, input int len);
      int n = 0;
      while (!bmem_write && n < 50) begin
         tick();
         n++;
      end
      chk("wr_req_seen", bmem_write, 1);
      for (int j = 0; j < len; j++) begin
         bmem_ready = pat[j];
         tick();
      end
      bmem_ready = 1'b0;
   endtask

   task automatic wait_resp(input bit is_d);
      int n = 0;
      while (!(is_d ? d_resp : i_resp) && n < 50) begin
         tick();
         n++;
      end
      chk(is_d ? "d_resp_seen" : "i_resp_seen", is_d ? d_resp : i_resp, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      i_addr = '0; i_read = 1'b0;
      d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
      bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;
      repeat (2) tick();

      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_resp", i_resp, 0);
      chk("rst_d_resp", d_resp, 0);
      chk("rst_bmem_read", bmem_read, 0);
      chk("rst_bmem_write", bmem_write, 0);
      chk("rst_bmem_addr", bmem_addr, 0);
      chk("rst_bmem_wdata", bmem_wdata, 0);
      rst = 1'b1;
      tick();

      // I-cache read alone, ready after two cycles
      expect_read(1'b0, 32'h0000_1040, L1);
      i_addr = 32'h0000_1040;
      i_read = 1'b1;
      serve_read(32'h0000_1040, 2, L1, 1'b0, 4, 1'b0);
      wait_resp(1'b0);
      i_read = 1'b0;
      tick();

      // D-cache writeback with ready toggling 1,0,1,1,0,1
      expect_write(32'h0000_2000, LW);
      d_addr  = 32'h0000_2000;
      d_wdata = LW;
      d_write = 1'b1;
      serve_write(8'h2D, 6);
      wait_resp(1'b1);
      d_write = 1'b0;
      tick();

      // Reset so the round-robin pointer favours the D-cache again
      rst = 1'b0;
      tick();
      chk("rst2_i_rdata", i_rdata, 0);
      rst = 1'b1;
      tick();

      // Simultaneous reads, twice: expect D, I, D, I; unaligned I address
      for (int round = 0; round < 2; round++) begin
         logic [31:0]  ia, da, ia_al;
         logic [255:0] dl, il;
         ia    = (round == 0) ? 32'h0000_3017 : 32'h0000_3100;
         ia_al = (round == 0) ? 32'h0000_3000 : 32'h0000_3100;
         da    = (round == 0) ? 32'h0000_4000 : 32'h0000_4100;
         dl    = (round == 0) ? L3A : L3C;
         il    = (round == 0) ? L3B : L3D;
         expect_read(1'b1, da, dl);
         expect_read(1'b0, ia_al, il);
         i_addr = ia; d_addr = da;
         i_read = 1'b1; d_read = 1'b1;
         serve_read(da, 0, dl, 1'b0, 4, 1'b1);
         wait_resp(1'b1);
         d_read = 1'b0;
         serve_read(ia_al, 1, il, 1'b0, 4, 1'b0);
         wait_resp(1'b0);
         i_read = 1'b0;
         tick();
      end

      // Foreign read-return tag injected among the real beats
      expect_read(1'b1, 32'h0000_8000, L4);
      d_addr = 32'h0000_8000;
      d_read = 1'b1;
      serve_read(32'h0000_8000, 1, L4, 1'b1, 4, 1'b1);
      wait_resp(1'b1);
      d_read = 1'b0;
      tick();

      // d_read and d_write together act as a write; read lines are held
      expect_write(32'h0000_6000, LW2);
      d_addr  = 32'h0000_6000;
      d_wdata = LW2;
      d_read  = 1'b1;
      d_write = 1'b1;
      serve_write(8'h0F, 4);
      wait_resp(1'b1);
      d_read  = 1'b0;
      d_write = 1'b0;
      tick();
      chk("d_rdata_hold", d_rdata, L4);
      chk("i_rdata_hold", i_rdata, L3D);

      // Reset after beat 2 of a read, then re-issue
      expect_read(1'b0, 32'h0000_5040, L5A);
      i_addr = 32'h0000_5040;
      i_read = 1'b1;
      serve_read(32'h0000_5040, 0, L5A, 1'b0, 3, 1'b0);
      rst    = 1'b0;
      i_read = 1'b0;
      void'(exp_resp.pop_back());
      #1;
      chk("midrst_i_rdata", i_rdata, 0);
      chk("midrst_d_rdata", d_rdata, 0);
      chk("midrst_i_resp", i_resp, 0);
      chk("midrst_bmem_read", bmem_read, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      expect_read(1'b0, 32'h0000_5040, L5B);
      i_read = 1'b1;
      serve_read(32'h0000_5040, 0, L5B, 1'b0, 4, 1'b0);
      wait_resp(1'b0);
      i_read = 1'b0;
      repeat (3) tick();

      chk("cmd_queue_drained", exp_cmd.size(), 0);
      chk("resp_queue_drained", exp_resp.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
